// File: rtl/seq_pp_multiplier.sv
// Iterative unsigned multiplier: accumulates ROWS_PER_CYCLE ANDed partial-product rows per cycle.
// Optional early exit when the remaining multiplier bits are zero: define SEQ_PP_MULT_EARLY_TERM_EN.

module seq_pp_row #(
  parameter int W2    = 16,
  parameter int SHIFT = 0
) (
  input  logic [W2-1:0] mcand,
  input  logic          sel,
  output logic [W2-1:0] row
);
  assign row = sel ? (mcand << SHIFT) : '0;
endmodule

module seq_pp_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int ITERS = WIDTH / ROWS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                              state;
  logic [PW-1:0]                       mcand;
  logic [WIDTH-1:0]                    mplier;
  logic [PW-1:0]                       acc;
  logic [CW-1:0]                       cnt;
  logic [ROWS_PER_CYCLE-1:0][PW-1:0]   rows;
  logic [PW-1:0]                       acc_nxt;
  logic [WIDTH-1:0]                    mplier_nxt;
  logic                                last;

  // One row generator per multiplier bit consumed this cycle.
  for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
    seq_pp_row #(.W2(PW), .SHIFT(g)) u_row (
      .mcand (mcand),
      .sel   (mplier[g]),
      .row   (rows[g])
    );
  end

  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < ROWS_PER_CYCLE; k++) acc_nxt = acc_nxt + rows[k];
  end

  assign mplier_nxt = mplier >> ROWS_PER_CYCLE;

`ifdef SEQ_PP_MULT_EARLY_TERM_EN
  assign last = (cnt == CW'(ITERS - 1)) || (mplier_nxt == '0);
`else
  assign last = (cnt == CW'(ITERS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand    <= {{WIDTH{1'b0}}, a};
          mplier   <= b;
          acc      <= '0;
          cnt      <= '0;
          state    <= ACCUM;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        ACCUM: begin
          acc    <= acc_nxt;
          mcand  <= mcand << ROWS_PER_CYCLE;
          mplier <= mplier_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            p         <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pp_multiplier.sv
// Scoreboard bench for seq_pp_multiplier (WIDTH=8, ROWS_PER_CYCLE=2): directed cases plus random traffic.
module tb_seq_pp_multiplier;
  localparam int W     = 8;
  localparam int R     = 2;
  localparam int ITERS = W / R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;
  logic          busy;

  seq_pp_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             lat;
    int             acc_cyc;
  } exp_t;

  exp_t           sbq[$];
  int             ntests = 0;
  int             nfail  = 0;
  int             cyc    = 0;
  logic           rnd_rdy = 1'b0;
  logic           ov_prev = 1'b0;
  logic           hs = 1'b0;
  logic [2*W-1:0] held_p = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency from the multiplier's highest set bit, rows consumed per cycle.
  function automatic int exp_lat(input logic [W-1:0] bb);
`ifdef SEQ_PP_MULT_EARLY_TERM_EN
    int msb = -1;
    for (int i = 0; i < W; i++) if (bb[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 1 + R - 1) / R;
`else
    return ITERS;
`endif
  endfunction

  // Monitor: pops expected results when out_valid rises, checks protocol each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ov_prev = 1'b0;
      hs      = 1'b0;
    end else begin
      if (hs) begin
        chk("hs_out_valid_low", out_valid, 0);
        chk("hs_in_ready_high", in_ready, 1);
        chk("p_retained", p, held_p);
      end
      if (out_valid && !ov_prev) begin
        if (sbq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_out_valid: p=%0d with no product pending", p);
        end else begin
          e = sbq.pop_front();
          chk("product", p, e.p);
          chk("latency", cyc - e.acc_cyc, e.lat);
          held_p = p;
        end
      end else if (out_valid) begin
        chk("p_stable", p, held_p);
      end
      if (out_valid) begin
        chk("done_busy", busy, 1);
        chk("done_in_ready", in_ready, 0);
      end else if (sbq.size() > 0) begin
        chk("accum_busy", busy, 1);
        chk("accum_in_ready", in_ready, 0);
      end
      hs      = out_valid && out_ready;
      ov_prev = out_valid;
    end
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ntests++; nfail++;
      $display("FAIL issue_timeout: in_ready stuck at %0d, required 1", in_ready);
      return;
    end
    in_valid  = 1'b1;
    a         = aa;
    b         = bb;
    e.p       = (2*W)'(aa) * (2*W)'(bb);
    e.lat     = exp_lat(bb);
    e.acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    sbq.push_back(e);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    issue(8'd13, 8'd11);
    issue(8'd255, 8'd255);
    issue(8'd0, 8'hAA);
    issue(8'hAA, 8'd0);
    issue(8'h5A, 8'h01);
    issue(8'h02, 8'h80);
    issue(8'd7, 8'd9);
    wait_drain();

    // Backpressure: hold out_ready low for 5 cycles in DONE.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(8'd200, 8'd3);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_p", p, 600);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);

    // Reset in the middle of an accumulation.
    issue(8'h33, 8'h44);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_p", p, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd7, 8'd9);
    wait_drain();

    // Random back-to-back traffic with random consumer stalls.
    @(negedge clk);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) issue(W'($urandom), W'($urandom));
    @(negedge clk);
    rnd_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
